fifo_pop_adapter: RTL and testbench

- Downstream consumer of the shared buffering fifo; converts its pop interface into a registered valid/ready stream.
- The fifo's interface is read-strobe, one-cycle-late data, with count-based ready.
- Issues fifo reads only when legal, tracks the in-flight read, and captures returned words into a 2-entry output skid buffer.
- Sustains one word per cycle when the consumer never stalls.
- Sits between every command/ray fifo and its consuming pipeline stage.

---
 rtl/fifo_pop_adapter_pkg.sv | 24 ++
 rtl/fifo_pop_adapter_chk.sv | 22 ++
 rtl/fifo_pop_adapter_skid_buffer2.sv | 68 ++++++
 rtl/fifo_pop_adapter.sv | 71 +++++++
 tb/tb_fifo_pop_adapter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pop_adapter_pkg.sv
// Shared types for the fifo pop adapter and other stream stages.
// Holds the word width and the skid-buffer occupancy states.
package fifo_pop_adapter_pkg;

   localparam int WORD_WIDTH = 32;
   localparam int SKID_DEPTH = 2;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_t;

   function automatic logic [1:0] skid_count(input skid_state_t state);
      logic [1:0] count;
      case (state)
         SKID_ONE: count = 2'd1;
         SKID_TWO: count = 2'd2;
         default:  count = 2'd0;
      endcase
      return count;
   endfunction

endpackage

// File: rtl/fifo_pop_adapter_chk.sv
// Simulation-only invariants for the pop adapter: no overflow of the
// skid buffer and no read strobe toward an empty fifo.
module fifo_pop_adapter_chk (
   input logic       clk,
   input logic       reset_n,
   input logic       fifo_ready,
   input logic       fifo_read,
   input logic [1:0] occupancy,
   input logic       inflight
);

   logic [2:0] occ_sum_s;

   assign occ_sum_s = {1'b0, occupancy} + {2'b00, inflight};

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      occ_sum_s <= 3'd2);

   a_read_needs_ready: assert property (@(posedge clk) disable iff (!reset_n)
      fifo_read |-> fifo_ready);

endmodule

// File: rtl/fifo_pop_adapter_skid_buffer2.sv
// Two-entry skid buffer with push/pop/flush; entry 0 is always the head.
// Reusable by any stream stage that needs one cycle of capture slack.
module skid_buffer2
   import fifo_pop_adapter_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       occupancy
);

   skid_state_t      state_r;
   logic [WIDTH-1:0] entry0_r;
   logic [WIDTH-1:0] entry1_r;

   // Occupancy state and entry shifting; flush wins over push and pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= SKID_EMPTY;
         entry0_r <= {WIDTH{1'b0}};
         entry1_r <= {WIDTH{1'b0}};
      end else if (flush) begin
         state_r <= SKID_EMPTY;
      end else begin
         case (state_r)
            SKID_EMPTY: begin
               if (push) begin
                  state_r  <= SKID_ONE;
                  entry0_r <= push_data;
               end
            end
            SKID_ONE: begin
               if (push && pop) begin
                  entry0_r <= push_data;
               end else if (push) begin
                  state_r  <= SKID_TWO;
                  entry1_r <= push_data;
               end else if (pop) begin
                  state_r <= SKID_EMPTY;
               end
            end
            SKID_TWO: begin
               if (pop) begin
                  entry0_r <= entry1_r;
                  if (push) begin
                     entry1_r <= push_data;
                  end else begin
                     state_r <= SKID_ONE;
                  end
               end
            end
            default: state_r <= SKID_EMPTY;
         endcase
      end
   end

   assign head_valid = (state_r != SKID_EMPTY);
   assign head_data  = entry0_r;
   assign occupancy  = skid_count(state_r);

endmodule

// File: rtl/fifo_pop_adapter.sv
// Converts the read-strobe / late-data fifo pop interface into a
// valid/ready stream backed by a two-entry skid buffer.
module fifo_pop_adapter
   import fifo_pop_adapter_pkg::*;
#(
   parameter int WIDTH     = WORD_WIDTH,
   parameter int BUF_DEPTH = SKID_DEPTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             fifo_ready,
   output logic             fifo_read,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   if (BUF_DEPTH != 2) begin : g_bad_depth
      $error("fifo_pop_adapter: BUF_DEPTH must be 2");
   end

   logic       inflight_r;
   logic       pop_s;
   logic       fifo_read_s;
   logic [2:0] pending_s;

   // Issue a read only if the word it returns is guaranteed a free slot.
   always_comb begin
      pop_s       = out_valid && out_ready;
      pending_s   = {1'b0, occupancy} + {2'b00, inflight_r} - {2'b00, pop_s};
      fifo_read_s = reset_n && fifo_ready && !flush && (pending_s <= 3'd1);
   end

   assign fifo_read = fifo_read_s;

   // The fifo returns data one cycle after the strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= fifo_read_s;
      end
   end

   skid_buffer2 #(
      .WIDTH(WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .push      (inflight_r),
      .push_data (fifo_data),
      .pop       (pop_s),
      .head_valid(out_valid),
      .head_data (out_data),
      .occupancy (occupancy)
   );

   fifo_pop_adapter_chk u_chk (
      .clk       (clk),
      .reset_n   (reset_n),
      .fifo_ready(fifo_ready),
      .fifo_read (fifo_read),
      .occupancy (occupancy),
      .inflight  (inflight_r)
   );

endmodule

// File: tb/tb_fifo_pop_adapter.sv
// Self-checking bench: fifo model, word-level scoreboard, directed tables
// and a randomized 10,000-word run.
module tb_fifo_pop_adapter;
   import fifo_pop_adapter_pkg::*;

   localparam int W = WORD_WIDTH;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         fifo_ready;
   logic         fifo_read;
   logic [W-1:0] fifo_data;
   logic         flush;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;

   always #5 clk = ~clk;

   fifo_pop_adapter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .fifo_ready(fifo_ready),
      .fifo_read (fifo_read),
      .fifo_data (fifo_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   typedef struct {
      bit          ready;
      bit          flsh;
      bit          rd;
      bit          valid;
      logic [1:0]  occ;
      logic [31:0] data;
   } vec_t;

   vec_t vecs[14];

   int checks   = 0;
   int failures = 0;

   // fq: words inside the upstream fifo; expq: words read but not yet
   // delivered or discarded, oldest first.
   logic [W-1:0] fq[$];
   logic [W-1:0] expq[$];
   bit           rd_prev    = 1'b0;
   bit           prev_stall = 1'b0;
   logic [W-1:0] prev_data;
   logic         s_read, s_valid;
   logic [1:0]   s_occ;
   logic [W-1:0] s_data;
   int           n_reads = 0;
   int           n_beats = 0;
   logic [W-1:0] last_beat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // One clock: sample and score at the falling edge, then model the fifo after the rising edge.
   task automatic cycle();
      int           outstanding;
      bit           pop;
      bit           exp_rd;
      bit           rd_now;
      logic [W-1:0] w;
      @(negedge clk);
      s_read  = fifo_read;
      s_valid = out_valid;
      s_occ   = occupancy;
      s_data  = out_data;
      outstanding = expq.size();
      pop    = s_valid && out_ready;
      exp_rd = fifo_ready && !flush && ((outstanding - int'(pop)) <= 1);
      check("fifo_read", 32'(s_read), 32'(exp_rd));
      check("occupancy", 32'(s_occ), 32'(outstanding - int'(rd_prev)));
      check("out_valid", 32'(s_valid), 32'((outstanding - int'(rd_prev)) != 0));
      check("occ_plus_inflight_le2", 32'((int'(s_occ) + int'(rd_prev)) <= 2), 32'd1);
      if (s_valid && outstanding > 0) check("out_data", s_data, expq[0]);
      if (prev_stall) check("hold_data", s_data, prev_data);
      if (pop) begin
         n_beats++;
         last_beat = s_data;
         if (expq.size() > 0) void'(expq.pop_front());
      end
      if (flush) expq.delete();
      prev_stall = s_valid && !out_ready && !flush;
      prev_data  = s_data;
      if (s_read) n_reads++;
      rd_now = s_read;
      @(posedge clk);
      #1;
      if (rd_now) begin
         if (fq.size() > 0) begin
            w = fq.pop_front();
            expq.push_back(w);
         end else begin
            w = $urandom();
         end
         fifo_data = w;
      end
      rd_prev    = rd_now;
      fifo_ready = (fq.size() > 0);
   endtask

   task automatic drain(input int budget);
      out_ready = 1'b1;
      flush     = 1'b0;
      for (int i = 0; i < budget && (fq.size() != 0 || expq.size() != 0); i++) cycle();
      check("drained", 32'(fq.size() + expq.size()), 32'd0);
   endtask

   task automatic preload(input logic [W-1:0] base, input int n);
      for (int i = 0; i < n; i++) fq.push_back(base + W'(i));
      fifo_ready = (fq.size() > 0);
   endtask

   task automatic run_rows(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         out_ready = vecs[i].ready;
         flush     = vecs[i].flsh;
         cycle();
         check($sformatf("row%0d_read", i), 32'(s_read), 32'(vecs[i].rd));
         check($sformatf("row%0d_valid", i), 32'(s_valid), 32'(vecs[i].valid));
         check($sformatf("row%0d_occ", i), 32'(s_occ), 32'(vecs[i].occ));
         if (vecs[i].valid) check($sformatf("row%0d_data", i), s_data, vecs[i].data);
      end
   endtask

   task automatic wait_beat(input string name, input logic [W-1:0] want, input int budget);
      int start;
      start = n_beats;
      for (int i = 0; i < budget && n_beats == start; i++) cycle();
      check({name, "_seen"}, 32'(n_beats != start), 32'd1);
      check(name, last_beat, want);
   endtask

   initial begin
      logic [W-1:0] head;
      int           reads0, beats0, sent, cyc;

      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h22};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h33};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h44};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'hA0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'hA0};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 32'hA0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'hA1};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'hA1};

      reset_n    = 1'b0;
      fifo_ready = 1'b0;
      fifo_data  = {W{1'b0}};
      flush      = 1'b0;
      out_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_occupancy", 32'(occupancy), 32'd0);
      check("reset_fifo_read", 32'(fifo_read), 32'd0);
      check("reset_out_data", out_data, 32'd0);
      reset_n = 1'b1;

      // Full-rate stream of four words, then backpressure with a single pop.
      preload(32'h11, 1);
      preload(32'h22, 1);
      preload(32'h33, 1);
      preload(32'h44, 1);
      run_rows(0, 6);
      preload(32'hA0, 8);
      run_rows(7, 13);

      // Flush with the buffer full; reads resume with the fifo head.
      head  = fq[0];
      flush = 1'b1;
      cycle();
      check("flush_full_read", 32'(s_read), 32'd0);
      flush = 1'b0;
      cycle();
      check("flush_full_valid", 32'(s_valid), 32'd0);
      check("flush_full_occ", 32'(s_occ), 32'd0);
      out_ready = 1'b1;
      wait_beat("flush_full_next", head, 10);

      // Flush in steady state with a read in flight and a coincident pop.
      drain(50);
      preload(32'hB0, 8);
      out_ready = 1'b1;
      repeat (3) cycle();
      flush = 1'b1;
      head  = fq[0];
      cycle();
      check("flush_stream_read", 32'(s_read), 32'd0);
      check("flush_stream_occ", 32'(s_occ), 32'd1);
      flush = 1'b0;
      cycle();
      check("flush_stream_valid", 32'(s_valid), 32'd0);
      check("flush_stream_occ_after", 32'(s_occ), 32'd0);
      wait_beat("flush_stream_next", head, 10);
      drain(50);

      // Single word: one read, one beat.
      reads0 = n_reads;
      beats0 = n_beats;
      preload(32'hAB, 1);
      out_ready = 1'b1;
      repeat (6) cycle();
      check("single_reads", 32'(n_reads - reads0), 32'd1);
      check("single_beats", 32'(n_beats - beats0), 32'd1);
      check("single_data", last_beat, 32'hAB);
      check("single_occ", 32'(s_occ), 32'd0);

      // Asynchronous reset mid-stream.
      preload(32'hC0, 8);
      out_ready = 1'b0;
      repeat (4) cycle();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_occupancy", 32'(occupancy), 32'd0);
      check("midrst_fifo_read", 32'(fifo_read), 32'd0);
      @(posedge clk);
      #1;
      reset_n    = 1'b1;
      expq.delete();
      rd_prev    = 1'b0;
      prev_stall = 1'b0;
      head       = fq[0];
      out_ready  = 1'b1;
      wait_beat("midrst_next", head, 10);
      drain(50);

      // Random fill and random backpressure over 10,000 words.
      beats0 = n_beats;
      sent   = 0;
      cyc    = 0;
      while ((n_beats - beats0) < 10000 && cyc < 60000) begin
         if (sent < 10000 && $urandom_range(0, 1) == 1) begin
            fq.push_back(W'($urandom()));
            sent++;
            fifo_ready = 1'b1;
         end
         out_ready = 1'($urandom_range(0, 1));
         cycle();
         cyc++;
      end
      check("random_delivered", 32'(n_beats - beats0), 32'd10000);
      check("random_left", 32'(fq.size() + expq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
